// File: rtl/dpram_pingpong_pkg.sv
// Shared types and default parameters for the ping-pong DPRAM controller.
package dpram_pingpong_pkg;

    localparam int unsigned DPRAM_DW      = 32;
    localparam int unsigned DPRAM_AW      = 9;
    localparam int unsigned DPRAM_N_DELAY = 1;

    typedef enum logic [1:0] {
        R_IDLE,
        R_READ,
        R_DRAIN
    } rd_state_e;

endpackage

// File: rtl/dpram_pingpong_ctrl_if.sv
// Write-stream, read-control, DPRAM and status signals of the ping-pong controller.
interface dpram_pingpong_ctrl_if
    import dpram_pingpong_pkg::*;
#(
    parameter int unsigned DW = DPRAM_DW,
    parameter int unsigned AW = DPRAM_AW
);

    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;

    logic          rd_start;
    logic          rd_busy;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;

    logic          ram_ena;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dia;
    logic          ram_enb;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_dob;

    logic [1:0]    bank_full;

    // Controller side.
    modport slave (
        input  wr_valid, wr_data, rd_start, ram_dob,
        output wr_ready, rd_busy, rd_valid, rd_data, rd_last,
        output ram_ena, ram_wea, ram_addra, ram_dia, ram_enb, ram_addrb, bank_full
    );

    // Producer / consumer / RAM side.
    modport master (
        output wr_valid, wr_data, rd_start, ram_dob,
        input  wr_ready, rd_busy, rd_valid, rd_data, rd_last,
        input  ram_ena, ram_wea, ram_addra, ram_dia, ram_enb, ram_addrb, bank_full
    );

endinterface

// File: rtl/dpram_bank_ptr.sv
// Wrapping word pointer for one DPRAM bank; tc_o flags the last word of the bank.
module dpram_bank_ptr #(
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc_i,
    output logic [$clog2(Depth)-1:0] ptr_o,
    output logic                     tc_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW-1:0] ptr_q, ptr_d;

    always_comb begin
        tc_o  = (ptr_q == PtrW'(Depth - 1));
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = tc_o ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/dpram_pingpong_ctrl.sv
// Ping-pong bank controller: fills one DPRAM half while the other is read out.
// Optional DPRAM_PINGPONG_REPEAT_EN adds cfg_rd_repeat for multi-pass bank reads.
module dpram_pingpong_ctrl
    import dpram_pingpong_pkg::*;
#(
    parameter int unsigned DW      = DPRAM_DW,
    parameter int unsigned AW      = DPRAM_AW,
    parameter int unsigned N_DELAY = DPRAM_N_DELAY
) (
    input  logic       clk,
    input  logic       rst,
`ifdef DPRAM_PINGPONG_REPEAT_EN
    input  logic [3:0] cfg_rd_repeat,
`endif
    dpram_pingpong_ctrl_if.slave bus
);

    localparam int unsigned BANK_DEPTH = 2 ** (AW - 1);
    localparam int unsigned PW         = AW - 1;
    localparam int unsigned DCW        = (N_DELAY > 1) ? $clog2(N_DELAY) : 1;

    rd_state_e        state_q, state_d;
    logic [1:0]       bank_full_q, bank_full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [N_DELAY-1:0] vld_pipe_q, vld_pipe_d;
    logic [N_DELAY-1:0] last_pipe_q, last_pipe_d;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          wr_tc, rd_tc;
    logic          wr_ready, wr_fire, wr_wrap;
    logic          rd_accept, rd_issue, ram_enb, drain_done, more_passes;

    dpram_bank_ptr #(
        .Depth (BANK_DEPTH)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (wr_fire),
        .ptr_o (wr_ptr),
        .tc_o  (wr_tc)
    );

    dpram_bank_ptr #(
        .Depth (BANK_DEPTH)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (rd_issue),
        .ptr_o (rd_ptr),
        .tc_o  (rd_tc)
    );

    assign wr_ready   = ~rst & ~bank_full_q[wr_bank_q];
    assign wr_fire    = bus.wr_valid & wr_ready;
    assign wr_wrap    = wr_fire & wr_tc;
    assign rd_accept  = (state_q == R_IDLE) & bus.rd_start & bank_full_q[rd_bank_q];
    assign drain_done = (state_q == R_DRAIN) & (drain_cnt_q == DCW'(N_DELAY - 1));

`ifdef DPRAM_PINGPONG_REPEAT_EN
    // Remaining extra passes over the current bank after the one in flight.
    logic [3:0] pass_cnt_q, pass_cnt_d;

    always_comb begin
        pass_cnt_d = pass_cnt_q;
        if (rd_accept) begin
            pass_cnt_d = cfg_rd_repeat;
        end else if (rd_issue && rd_tc && (pass_cnt_q != 4'd0)) begin
            pass_cnt_d = pass_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt_q <= 4'd0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
        end
    end

    assign more_passes = (pass_cnt_q != 4'd0);
`else
    assign more_passes = 1'b0;
`endif

    // Read FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= R_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            R_IDLE:  if (rd_accept) state_d = R_READ;
            R_READ:  if (rd_tc && !more_passes) state_d = R_DRAIN;
            R_DRAIN: if (drain_done) state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    // Read FSM: outputs. Everything is forced low while rst is held.
    always_comb begin
        rd_issue      = (state_q == R_READ);
        ram_enb       = rd_issue & ~rst;
        bus.rd_busy   = (state_q != R_IDLE) & ~rst;
        bus.ram_enb   = ram_enb;
        bus.ram_addrb = ram_enb ? {rd_bank_q, rd_ptr} : '0;
        bus.rd_valid  = vld_pipe_q[N_DELAY-1] & ~rst;
        bus.rd_last   = last_pipe_q[N_DELAY-1] & vld_pipe_q[N_DELAY-1] & ~rst;
        bus.rd_data   = bus.rd_valid ? bus.ram_dob : '0;
    end

    always_comb begin
        bus.wr_ready  = wr_ready;
        bus.ram_ena   = wr_fire;
        bus.ram_wea   = wr_fire;
        bus.ram_addra = wr_fire ? {wr_bank_q, wr_ptr} : '0;
        bus.ram_dia   = wr_fire ? bus.wr_data : '0;
        bus.bank_full = rst ? 2'b00 : bank_full_q;
    end

    // Bank bookkeeping. The writer only ever fills an empty bank and the reader only
    // releases a full one, so set and clear never target the same bit.
    always_comb begin
        bank_full_d = bank_full_q;
        if (wr_wrap) bank_full_d[wr_bank_q] = 1'b1;
        if (drain_done) bank_full_d[rd_bank_q] = 1'b0;
        wr_bank_d   = wr_bank_q ^ wr_wrap;
        rd_bank_d   = rd_bank_q ^ drain_done;
        drain_cnt_d = ((state_q == R_DRAIN) && !drain_done) ? drain_cnt_q + DCW'(1) : '0;

        vld_pipe_d     = vld_pipe_q;
        last_pipe_d    = last_pipe_q;
        vld_pipe_d[0]  = ram_enb;
        last_pipe_d[0] = ram_enb & rd_tc;
        for (int i = 1; i < N_DELAY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full_q <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            drain_cnt_q <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            drain_cnt_q <= drain_cnt_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
        end
    end

endmodule

// File: tb/tb_dpram_pingpong_ctrl.sv
// Scoreboard bench for dpram_pingpong_ctrl with AW=3 (4-word banks), N_DELAY=1.
module tb_dpram_pingpong_ctrl;

    localparam int unsigned DW      = 32;
    localparam int unsigned AW      = 3;
    localparam int unsigned N_DELAY = 1;
    localparam int unsigned BD      = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dpram_pingpong_ctrl_if #(.DW(DW), .AW(AW)) bus ();

`ifdef DPRAM_PINGPONG_REPEAT_EN
    logic [3:0] cfg_rd_repeat = 4'd0;
`endif

    dpram_pingpong_ctrl #(
        .DW      (DW),
        .AW      (AW),
        .N_DELAY (N_DELAY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef DPRAM_PINGPONG_REPEAT_EN
        .cfg_rd_repeat (cfg_rd_repeat),
`endif
        .bus           (bus)
    );

    // Behavioural DPRAM with one-cycle read latency.
    logic [DW-1:0] mem [2*BD];
    logic [DW-1:0] dob_q = '0;
    always @(posedge clk) begin
        if (bus.ram_ena && bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dia;
        if (bus.ram_enb) dob_q <= mem[bus.ram_addrb];
    end
    assign bus.ram_dob = dob_q;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    logic [AW+DW-1:0] wr_q [$];
    logic [AW-1:0]    ra_q [$];
    logic [DW:0]      rd_q [$];
    logic [DW-1:0]    mem_exp [2*BD];
    int               exp_wa = 0;
    int               last_cnt = 0;
    logic             prev_enb = 1'b0;

    logic [AW+DW-1:0] m_we;
    logic [AW-1:0]    m_ra;
    logic [DW:0]      m_rd;

    always @(negedge clk) begin
        if (bus.ram_ena) begin
            if (wr_q.size() == 0) begin
                check_eq("wr_unexpected", bus.ram_ena, 0);
            end else begin
                m_we = wr_q.pop_front();
                check_eq("wr_addr", bus.ram_addra, m_we[AW+DW-1:DW]);
                check_eq("wr_data", bus.ram_dia, m_we[DW-1:0]);
                check_eq("wr_wea", bus.ram_wea, 1);
            end
        end
        if (bus.ram_enb) begin
            if (ra_q.size() == 0) begin
                check_eq("rd_addr_unexpected", bus.ram_enb, 0);
            end else begin
                m_ra = ra_q.pop_front();
                check_eq("rd_addr", bus.ram_addrb, m_ra);
            end
        end
        if (bus.rd_valid || prev_enb) begin
            check_eq("rd_valid_latency", bus.rd_valid, prev_enb && !rst);
        end
        if (bus.rd_valid) begin
            if (rd_q.size() == 0) begin
                check_eq("rd_unexpected", bus.rd_valid, 0);
            end else begin
                m_rd = rd_q.pop_front();
                check_eq("rd_data", bus.rd_data, m_rd[DW-1:0]);
                check_eq("rd_last", bus.rd_last, m_rd[DW]);
            end
        end
        if (bus.rd_last) last_cnt++;
        prev_enb <= bus.ram_enb;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input logic [DW-1:0] base, input int n, input bit pulse_rd);
        for (int i = 0; i < n; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = base + DW'(i);
            wr_q.push_back({AW'(exp_wa), base + DW'(i)});
            mem_exp[exp_wa] = base + DW'(i);
            exp_wa = (exp_wa + 1) % (2 * BD);
            if (pulse_rd && i == 0) bus.rd_start = 1'b1;
            tick();
            bus.rd_start = 1'b0;
        end
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
    endtask

    task automatic expect_read(input int bank, input int passes);
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < BD; i++) begin
                ra_q.push_back(AW'(bank * BD + i));
                rd_q.push_back({(i == BD - 1), mem_exp[bank * BD + i]});
            end
        end
    endtask

    task automatic start_read(input int bank, input int passes);
        expect_read(bank, passes);
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output logic rdy_before);
        int n = 0;
        rdy_before = bus.wr_ready;
        @(negedge clk);
        while (bus.rd_busy && n < bound) begin
            rdy_before = bus.wr_ready;
            @(negedge clk);
            n++;
        end
        check_eq("rd_idle", bus.rd_busy, 0);
    endtask

    task automatic check_rst(input string tag);
        check_eq({tag, "_ctl"}, {bus.wr_ready, bus.rd_busy, bus.rd_valid, bus.rd_last,
                               bus.ram_ena, bus.ram_wea, bus.ram_enb, bus.bank_full}, 0);
        check_eq({tag, "_addr"}, {bus.ram_addra, bus.ram_addrb}, 0);
        check_eq({tag, "_data"}, {bus.ram_dia, bus.rd_data}, 0);
    endtask

    logic rdy_b;

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_start = 1'b0;

        // Reset state.
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_rst("por");
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("por_wr_ready", bus.wr_ready, 1);
        check_eq("por_bank_full", bus.bank_full, 0);
        tick();

        // Fill bank 0, then read it with a second rd_start mid-pass that must be ignored.
        write_words(32'h10, 4, 1'b0);
        @(negedge clk);
        check_eq("fill0_bank_full", bus.bank_full, 2'b01);
        check_eq("fill0_wr_ready", bus.wr_ready, 1);
        tick();
        expect_read(0, 1);
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        tick();
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        wait_idle(20, rdy_b);
        check_eq("read0_bank_full", bus.bank_full, 2'b00);
        tick();

        // rd_start while nothing is full.
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        @(negedge clk);
        check_eq("ignored_busy", bus.rd_busy, 0);
        tick();
        @(negedge clk);
        check_eq("ignored_busy2", bus.rd_busy, 0);
        tick();

        // Fill bank 1, start reading it, then reset during the second read cycle.
        write_words(32'h20, 4, 1'b0);
        @(negedge clk);
        check_eq("fill1_bank_full", bus.bank_full, 2'b10);
        tick();
        ra_q.push_back(AW'(4));
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        tick();
        rst = 1'b1;
        ra_q.delete();
        rd_q.delete();
        @(negedge clk);
        check_rst("rst_gate");
        tick();
        @(negedge clk);
        check_rst("rst_abort");
        tick();
        rst = 1'b0;
        exp_wa = 0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_busy", bus.rd_busy, 0);
        check_eq("post_rst_wr_ready", bus.wr_ready, 1);
        tick();

        // Fill both banks; writer stalls until the reader releases bank 0.
        write_words(32'h30, 8, 1'b0);
        @(negedge clk);
        check_eq("both_full_wr_ready", bus.wr_ready, 0);
        check_eq("both_full_bank_full", bus.bank_full, 2'b11);
        tick();
        start_read(0, 1);
        wait_idle(20, rdy_b);
        check_eq("release_rdy_before", rdy_b, 0);
        check_eq("release_rdy_after", bus.wr_ready, 1);
        check_eq("release_bank_full", bus.bank_full, 2'b10);
        tick();

        // Read bank 1 while concurrently refilling bank 0.
        expect_read(1, 1);
        write_words(32'h40, 4, 1'b1);
        wait_idle(20, rdy_b);
        check_eq("concurrent_bank_full", bus.bank_full, 2'b01);
        tick();
        start_read(0, 1);
        wait_idle(20, rdy_b);
        check_eq("reread0_bank_full", bus.bank_full, 2'b00);
        tick();

`ifdef DPRAM_PINGPONG_REPEAT_EN
        write_words(32'h50, 4, 1'b0);
        cfg_rd_repeat = 4'd2;
        last_cnt = 0;
        start_read(1, 3);
        cfg_rd_repeat = 4'd0;
        wait_idle(40, rdy_b);
        check_eq("repeat_last_pulses", last_cnt, 3);
        check_eq("repeat_bank_full", bus.bank_full, 2'b00);
        tick();
`endif

        repeat (3) tick();
        check_eq("wr_q_left", wr_q.size(), 0);
        check_eq("ra_q_left", ra_q.size(), 0);
        check_eq("rd_q_left", rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dpram_pingpong_ctrl.md
DPRAM_PINGPONG_CTRL -- requirements
Module: dpram_pingpong_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): DW, 32, data word width; AW, 9, DPRAM address width; N_DELAY, 1, DPRAM read latency in cycles.
REQ-002 SHALL derive BANK_DEPTH = 2**(AW-1); bank select is addr[AW-1], word pointer is addr[AW-2:0].
REQ-003 SHALL have port clk, input, 1, single clock; synchronous active-high reset, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have write-stream ports: wr_valid in 1; wr_ready out 1; wr_data in DW.
REQ-006 SHALL have read-control ports: rd_start in 1, pulse to begin a bank read; rd_busy out 1; rd_valid out 1; rd_data out DW; rd_last out 1.
REQ-007 SHALL have DPRAM ports: ram_ena out 1; ram_wea out 1; ram_addra out AW; ram_dia out DW; ram_enb out 1; ram_addrb out AW; ram_dob in DW.
REQ-008 SHALL have status port bank_full out 2, one bit per bank.

Function
REQ-009 wr_ready SHALL equal NOT bank_full[wr_bank] and SHALL be 0 while rst is high.
REQ-010 On wr_valid AND wr_ready, same cycle: ram_ena=ram_wea=1, ram_addra={wr_bank,wr_ptr}, ram_dia=wr_data; otherwise ram_ena=ram_wea=0.
REQ-011 wr_ptr SHALL increment per accepted word; at BANK_DEPTH-1 it SHALL wrap to 0, set bank_full[wr_bank] and toggle wr_bank on the next edge.
REQ-012 Read FSM states SHALL be R_IDLE, R_READ, R_DRAIN; rd_busy=1 in any state other than R_IDLE.
REQ-013 R_IDLE->R_READ on rd_start AND bank_full[rd_bank]; rd_start is ignored when the bank is not full and in all non-idle states.
REQ-014 In R_READ: ram_enb=1, ram_addrb={rd_bank,rd_ptr}, rd_ptr increments each cycle; after issuing address BANK_DEPTH-1 -> R_DRAIN.
REQ-015 R_DRAIN SHALL last N_DELAY cycles with ram_enb=0, then clear bank_full[rd_bank], toggle rd_bank and return to R_IDLE.
REQ-016 rd_valid SHALL assert exactly N_DELAY cycles after each ram_enb cycle, with rd_data=ram_dob; rd_last SHALL mark the final word of a pass.
REQ-017 Set of bank_full on one bank and clear on the other in the same cycle SHALL both take effect; wr_ready for a just-cleared bank SHALL rise the following cycle.
REQ-018 Read of a bank and write to the other bank SHALL proceed concurrently with no stall; throughput one word per cycle per side.

Reset
REQ-019 On rst: bank_full=0, wr_bank=rd_bank=0, wr_ptr=rd_ptr=0, FSM=R_IDLE; all outputs 0 (wr_ready 0).
REQ-020 rst asserted mid-write or mid-read SHALL abort the operation; partially written/read banks are discarded and no rd_valid is issued after rst.

Configuration
REQ-021 Macro DPRAM_PINGPONG_REPEAT_EN SHALL add input cfg_rd_repeat[3:0], sampled at accepted rd_start.
REQ-022 With DPRAM_PINGPONG_REPEAT_EN: bank read cfg_rd_repeat+1 passes back-to-back without further rd_start; rd_last on each pass's final word; bank released only after the final pass's drain.
REQ-023 Without the macro: port absent, exactly one pass per rd_start.

Structure
REQ-024 Package dpram_pingpong_pkg SHALL hold the read-state enum and default DW/AW/N_DELAY constants.
REQ-025 One sub-module dpram_bank_ptr (wrapping counter with terminal-count flag) SHALL be instantiated for each of the write and read pointers.
REQ-026 Controller SHALL NOT instantiate the DPRAM; integration connects ram_* ports to the team's dpram_wrapper.

Verification (AW=3, BANK_DEPTH=4, N_DELAY=1)
REQ-027 Write 0x10..0x13 continuous -> addra 0..3, bank_full=01 after fourth word, wr_bank=1.
REQ-028 rd_start after bank 0 full -> addrb 0..3 over 4 cycles, rd_valid data 0x10..0x13 one cycle later, rd_last on 0x13, bank_full[0] cleared after drain.
REQ-029 Write 8 words with no read -> wr_ready=0 after word 8, bank_full=11; rd_start then releases bank 0 and wr_ready=1 the cycle after.
REQ-030 rd_start with bank_full=00 and rd_start during R_READ -> ignored, no ram_enb.
REQ-031 rst asserted during cycle 2 of R_READ -> next cycle all outputs 0, bank_full=00, no further rd_valid.
REQ-032 With DPRAM_PINGPONG_REPEAT_EN, cfg_rd_repeat=2 -> 12 rd_valid words, three rd_last pulses, bank released once.
